// File: rtl/rle_pkg.sv
// rle_pkg: shared types and defaults for the RLE pixel decoder.
//   LEN_W / COLOUR_W : default run-length and colour field widths
//   run_t            : one run-length entry {len_m1, colour}, colour in LSBs
//   UNDERRUN_COLOUR  : colour shown on an active pixel with no run available
package rle_pkg;

    localparam int LEN_W    = 10;
    localparam int COLOUR_W = 6;

    localparam logic [COLOUR_W-1:0] UNDERRUN_COLOUR = 6'b110011;

    typedef struct packed {
        logic [LEN_W-1:0]    len_m1;
        logic [COLOUR_W-1:0] colour;
    } run_t;

endpackage

// File: rtl/rle_run_fifo2.sv
// rle_run_fifo2: two-entry run buffer with a synchronous flush.
// Ports:
//   clk, reset  : pixel clock, synchronous active-high reset
//   flush       : empties the buffer on the next edge (wins over push/pop)
//   push, din   : write one entry; ignored when full
//   pop         : drop the head entry; ignored when empty
//   dout        : head entry (valid while !empty)
//   full, empty : occupancy flags
module rle_run_fifo2
    import rle_pkg::*;
#(
    parameter int W = $bits(run_t)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push_ok, pop_ok;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign dout    = mem_q[rd_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = din;
                wr_d        = ~wr_q;
            end
            if (pop_ok) begin
                rd_d = ~rd_q;
            end
            cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
        // Storage needs no reset: it is only read while cnt_q says it is valid.
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rle_pixel_decoder.sv
// rle_pixel_decoder: expands run-length entries into one RGB222 colour per
// active pixel, paced by the timing chain's pixel_en / blank.
// Ports:
//   clk, reset      : pixel clock, synchronous active-high reset
//   run_data        : {length_minus_1, colour} from the fetch stage
//   run_valid/ready : stream handshake for run_data
//   pixel_en, blank : timing chain pixel enable and combined blank
//   frame_start     : one-cycle pulse, flushes all run state
//   restart         : one-cycle pulse asking the fetch stage to rewind
//   colour          : registered pixel colour (one cycle after the pixel)
//   underrun        : sticky, an active pixel had no run available
//   underrun_count  : only with RLE_UNDERRUN_CNT_EN, saturating 8-bit count
//                     of underrun pixels
module rle_pixel_decoder
    import rle_pkg::*;
#(
    parameter int                          LEN_W           = rle_pkg::LEN_W,
    parameter int                          COLOUR_W        = rle_pkg::COLOUR_W,
    parameter logic [COLOUR_W-1:0]         UNDERRUN_COLOUR = rle_pkg::UNDERRUN_COLOUR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LEN_W+COLOUR_W-1:0] run_data,
    input  logic                      run_valid,
    output logic                      run_ready,
    input  logic                      pixel_en,
    input  logic                      blank,
    input  logic                      frame_start,
    output logic                      restart,
    output logic [COLOUR_W-1:0]       colour,
    output logic                      underrun
`ifdef RLE_UNDERRUN_CNT_EN
    ,
    output logic [7:0]                underrun_count
`endif
);

    localparam int RW = LEN_W + COLOUR_W;

    logic [RW-1:0]       head;
    logic                fifo_full, fifo_empty;
    logic                push, pop;
    logic                consume;

    logic                cur_vld_q, cur_vld_d;
    logic [COLOUR_W-1:0] cur_col_q, cur_col_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                restart_q, restart_d;
    logic                underrun_q, underrun_d;
`ifdef RLE_UNDERRUN_CNT_EN
    logic [7:0]          ucnt_q, ucnt_d;
`endif

    assign consume   = pixel_en && !blank;
    assign run_ready = !fifo_full && !reset && !frame_start;
    assign push      = run_valid && run_ready;

    rle_run_fifo2 #(.W(RW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (frame_start),
        .push  (push),
        .din   (run_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        cur_vld_d  = cur_vld_q;
        cur_col_d  = cur_col_q;
        rem_d      = rem_q;
        colour_d   = colour_q;
        underrun_d = underrun_q;
        restart_d  = 1'b0;
        pop        = 1'b0;
`ifdef RLE_UNDERRUN_CNT_EN
        ucnt_d     = ucnt_q;
`endif
        if (frame_start) begin
            cur_vld_d  = 1'b0;
            cur_col_d  = '0;
            rem_d      = '0;
            colour_d   = '0;
            underrun_d = 1'b0;
            restart_d  = 1'b1;
`ifdef RLE_UNDERRUN_CNT_EN
            ucnt_d     = '0;
`endif
        end else if (consume && cur_vld_q) begin
            colour_d = cur_col_q;
            if (rem_q == '0) begin
                // Last pixel of this run: pull the next one in the same edge
                // so consecutive runs have no bubble.
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    cur_col_d = head[COLOUR_W-1:0];
                    rem_d     = head[RW-1:COLOUR_W];
                end else begin
                    cur_vld_d = 1'b0;
                end
            end else begin
                rem_d = rem_q - LEN_W'(1);
            end
        end else begin
            if (consume) begin
                colour_d   = UNDERRUN_COLOUR;
                underrun_d = 1'b1;
`ifdef RLE_UNDERRUN_CNT_EN
                if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
`endif
            end else if (pixel_en) begin
                colour_d = '0;
            end
            // Idle load happens on any cycle; the underrun pixel above is not
            // retro-filled by a run that only just became current.
            if (!cur_vld_q && !fifo_empty) begin
                pop       = 1'b1;
                cur_vld_d = 1'b1;
                cur_col_d = head[COLOUR_W-1:0];
                rem_d     = head[RW-1:COLOUR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_vld_q  <= 1'b0;
            cur_col_q  <= '0;
            rem_q      <= '0;
            colour_q   <= '0;
            restart_q  <= 1'b0;
            underrun_q <= 1'b0;
`ifdef RLE_UNDERRUN_CNT_EN
            ucnt_q     <= '0;
`endif
        end else begin
            cur_vld_q  <= cur_vld_d;
            cur_col_q  <= cur_col_d;
            rem_q      <= rem_d;
            colour_q   <= colour_d;
            restart_q  <= restart_d;
            underrun_q <= underrun_d;
`ifdef RLE_UNDERRUN_CNT_EN
            ucnt_q     <= ucnt_d;
`endif
        end
    end

    assign colour   = colour_q;
    assign restart  = restart_q;
    assign underrun = underrun_q;
`ifdef RLE_UNDERRUN_CNT_EN
    assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_rle_pixel_decoder.sv
// Bench for rle_pixel_decoder: directed stimulus, a queue-based pixel model
// compared every cycle, plus literal expectations for the headline scenarios.
module tb_rle_pixel_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] run_data = '0;
    logic        run_valid = 1'b0;
    logic        run_ready;
    logic        pixel_en = 1'b0;
    logic        blank = 1'b0;
    logic        frame_start = 1'b0;
    logic        restart;
    logic [5:0]  colour;
    logic        underrun;
`ifdef RLE_UNDERRUN_CNT_EN
    logic [7:0]  underrun_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rle_pixel_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .run_data    (run_data),
        .run_valid   (run_valid),
        .run_ready   (run_ready),
        .pixel_en    (pixel_en),
        .blank       (blank),
        .frame_start (frame_start),
        .restart     (restart),
        .colour      (colour),
        .underrun    (underrun)
`ifdef RLE_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    // ---------------- behavioural model ----------------
    // q holds every accepted run still owed pixels; 'live' means its head is
    // the run the decoder is currently drawing from.
    typedef struct { logic [5:0] c; int n; } mrun_t;
    mrun_t q[$];
    bit       live = 0;
    logic [5:0] m_col = 0;
    bit       m_und = 0, m_rst = 0, m_push = 0, started = 0;
    int       m_cnt = 0;

    function automatic bit model_ready();
        return ((q.size() - int'(live)) < 2) && !reset && !frame_start;
    endfunction

    always @(posedge clk) begin
        bit    ok;
        mrun_t r;
        ok      = run_valid && model_ready();
        m_push  = 0;
        started = 1;
        if (reset) begin
            q.delete(); live = 0; m_col = 0; m_und = 0; m_rst = 0; m_cnt = 0;
        end else if (frame_start) begin
            q.delete(); live = 0; m_col = 0; m_und = 0; m_rst = 1; m_cnt = 0;
        end else begin
            m_rst = 0;
            if (pixel_en && !blank && live) begin
                m_col   = q[0].c;
                q[0].n  = q[0].n - 1;
                if (q[0].n == 0) begin
                    void'(q.pop_front());
                    live = (q.size() > 0);
                end
            end else begin
                if (pixel_en && !blank) begin
                    m_col = 6'h33;
                    m_und = 1;
                    if (m_cnt < 255) m_cnt++;
                end else if (pixel_en) begin
                    m_col = 0;
                end
                if (!live && q.size() > 0) live = 1;
            end
            if (ok) begin
                r.c = run_data[5:0];
                r.n = int'(run_data[15:6]) + 1;
                q.push_back(r);
                m_push = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("m_colour",    int'(colour),    int'(m_col));
            chk("m_underrun",  int'(underrun),  int'(m_und));
            chk("m_restart",   int'(restart),   int'(m_rst));
            chk("m_run_ready", int'(run_ready), int'(model_ready()));
`ifdef RLE_UNDERRUN_CNT_EN
            chk("m_ucount",    int'(underrun_count), m_cnt);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int len, input int c);
        run_valid = 1'b1;
        run_data  = {len[9:0], c[5:0]};
        tick();
        run_valid = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("restart_hi", int'(restart), 1);
        tick();
        chk("restart_lo", int'(restart), 0);
    endtask

    logic [15:0] tbl [4];
    logic [5:0]  seen [8];
    logic [5:0]  exp8 [8];

    initial begin
        int n15, nz, idx, got, n7;
        logic [5:0] prev, last;
        bit pe_prev;

        // ---- reset state ----
        tick(); tick();
        chk("rst_colour", int'(colour), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_restart", int'(restart), 0);
        chk("rst_ready", int'(run_ready), 0);
        reset = 1'b0;

        // ---- test 1: two runs then underrun ----
        push_run(3, 'h30);
        push_run(0, 'h0C);
        tick(); tick();
        pixel_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_run_a", int'(colour), 'h30);
        end
        tick();
        chk("t1_run_b", int'(colour), 'h0C);
        tick();
        chk("t1_under_col", int'(colour), 'h33);
        chk("t1_under_flag", int'(underrun), 1);
        pixel_en = 1'b0;

        // ---- test 2: 10-pixel run across a blank gap ----
        frame_pulse();
        chk("t2_und_clr", int'(underrun), 0);
        push_run(9, 'h15);
        tick(); tick();
        pixel_en = 1'b1;
        n15 = 0; nz = 0;
        for (int i = 0; i < 13; i++) begin
            blank = (i >= 2 && i <= 4);
            tick();
            if (colour == 6'h15) n15++;
            else if (colour == 6'h00) nz++;
        end
        blank = 1'b0;
        chk("t2_active_px", n15, 10);
        chk("t2_blank_px", nz, 3);
        tick();
        chk("t2_run_end", int'(colour), 'h33);
        pixel_en = 1'b0;

        // ---- test 3: full buffer back-pressure, no loss or duplication ----
        frame_pulse();
        tbl[0] = {10'd1, 6'h01}; tbl[1] = {10'd1, 6'h02};
        tbl[2] = {10'd1, 6'h03}; tbl[3] = {10'd1, 6'h04};
        exp8[0] = 6'h01; exp8[1] = 6'h01; exp8[2] = 6'h02; exp8[3] = 6'h02;
        exp8[4] = 6'h03; exp8[5] = 6'h03; exp8[6] = 6'h04; exp8[7] = 6'h04;
        idx = 0; got = 0;
        run_valid = 1'b1;
        run_data  = tbl[0];
        for (int i = 0; i < 40; i++) begin
            if (i == 8 && got < 8) pixel_en = 1'b1;
            if (i == 6) chk("t3_full_ready", int'(run_ready), 0);
            pe_prev = pixel_en;
            tick();
            if (m_push) begin
                idx++;
                if (idx < 4) run_data = tbl[idx];
                else run_valid = 1'b0;
            end
            if (pe_prev && got < 8) begin
                seen[got] = colour;
                got++;
                if (got == 8) pixel_en = 1'b0;
            end
        end
        run_valid = 1'b0;
        chk("t3_accepted", idx, 4);
        chk("t3_pixels", got, 8);
        for (int i = 0; i < 8; i++) chk("t3_seq", int'(seen[i]), int'(exp8[i]));

        // ---- test 4: frame_start mid-run with a full buffer ----
        frame_pulse();
        pixel_en = 1'b1;
        tick();
        pixel_en = 1'b0;
        chk("t4_und_set", int'(underrun), 1);
        idx = 0;
        run_valid = 1'b1;
        run_data  = {10'd20, 6'h2A};
        for (int i = 0; i < 10 && idx < 3; i++) begin
            tick();
            if (m_push) idx++;
        end
        run_valid = 1'b0;
        chk("t4_filled", idx, 3);
        pixel_en = 1'b1;
        tick(); tick();
        chk("t4_mid_run", int'(colour), 'h2A);
        pixel_en = 1'b0;
        frame_start = 1'b1;
        run_valid   = 1'b1;
        run_data    = {10'd0, 6'h3F};
        #1;
        chk("t4_fs_ready", int'(run_ready), 0);
        tick();
        frame_start = 1'b0;
        run_valid   = 1'b0;
        chk("t4_restart", int'(restart), 1);
        chk("t4_und_clr", int'(underrun), 0);
        chk("t4_col_clr", int'(colour), 0);
        tick();
        chk("t4_restart_1cyc", int'(restart), 0);
        pixel_en = 1'b1;
        tick();
        chk("t4_flushed", int'(colour), 'h33);
        pixel_en = 1'b0;

        // ---- test 5: pixel_en one cycle in four ----
        frame_pulse();
        push_run(2, 'h07);
        tick(); tick();
        n7 = 0; last = 0;
        for (int i = 0; i < 16; i++) begin
            pixel_en = (i % 4 == 0);
            pe_prev  = pixel_en;
            prev     = colour;
            tick();
            if (!pe_prev) chk("t5_hold", int'(colour), int'(prev));
            else if (colour == 6'h07) n7++;
            if (i == 12) last = colour;
        end
        pixel_en = 1'b0;
        chk("t5_run_len", n7, 3);
        chk("t5_after_run", int'(last), 'h33);

`ifdef RLE_UNDERRUN_CNT_EN
        // ---- test 6: underrun counter saturation ----
        frame_pulse();
        pixel_en = 1'b1;
        repeat (300) tick();
        pixel_en = 1'b0;
        chk("t6_cnt_sat", int'(underrun_count), 255);
        frame_pulse();
        chk("t6_cnt_clr", int'(underrun_count), 0);
`endif

        // ---- test 7: reset mid-run ----
        frame_pulse();
        push_run(50, 'h11);
        tick(); tick();
        pixel_en = 1'b1;
        tick(); tick();
        push_run(5, 'h22);
        pixel_en = 1'b0;
        reset = 1'b1;
        tick();
        chk("t7_rst_col", int'(colour), 0);
        chk("t7_rst_und", int'(underrun), 0);
        chk("t7_rst_restart", int'(restart), 0);
        chk("t7_rst_ready", int'(run_ready), 0);
        reset = 1'b0;
        tick();
        pixel_en = 1'b1;
        tick();
        chk("t7_empty_after_rst", int'(colour), 'h33);
        pixel_en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
